nios_system_pio_out_pulse: RTL
==============================

# nios_system_pio_out_pulse

Parametrised Avalon-MM output PIO for the Nios system. It replaces the fixed 2-bit write-only output port with a WIDTH-bit port that adds atomic set and clear registers and a hardware one-shot pulse mode timed by a programmable shared down-counter. It sits on the Nios data master interconnect and drives board-level control lines such as ESP mode select, relay and valve strobes, and LEDs.

## Interface
- WIDTH, 8: out_port width; valid range 1..32.
- RESET_VALUE, 0: value of out_port after reset (WIDTH bits).
- CNT_W, 16: pulse-length counter width; valid range 1..32.
- RESET_PULSE_LEN, 1000: PULSE_LEN register value after reset.
- clk, in, 1: system clock; the only clock.
- reset, in, 1: synchronous, active-high reset.
- address, in, 3: word offset of the register.
- chipselect, in, 1: slave select.
- write_n, in, 1: active-low write strobe; a write occurs on a clk edge where chipselect && !write_n.
- writedata, in, 32: write data.
- readdata, out, 32: read data; combinational from address; unused upper bits read as 0.
- out_port, out, WIDTH: registered output lines.

## Operation
- Register map:
  - 0 DATA: R/W. A write loads writedata[WIDTH-1:0] and clears the whole active mask, cancelling all pulses.
  - 1 PULSE_LEN: R/W, CNT_W bits.
  - 2 PULSE: a write with mask M sets data |= M and active |= M, then reloads the timer. A read returns the active mask.
  - 4 OUTSET: a write with mask M sets data |= M and active &= ~M, so those bits become static 1.
  - 5 OUTCLEAR: a write with mask M sets data &= ~M and active &= ~M.
  - 3, 6, 7: reserved; reads return 0 and writes are ignored.
- Timer FSM:
  - IDLE: counter = 0.
  - A PULSE write with a nonzero mask loads the counter with max(PULSE_LEN,1) and moves to RUN.
  - RUN: the counter decrements by 1 each cycle.
  - When counter == 1 with no PULSE write, the next edge clears data &= ~active, clears the active mask and returns to IDLE.
  - RUN also returns to IDLE early when the active mask becomes 0 through DATA, OUTSET or OUTCLEAR writes.
- A PULSE write with mask 0 has no effect.
- PULSE_LEN = 0 behaves as 1.
- Retrigger: a PULSE write during RUN reloads the shared counter. All active bits, old and new, then expire together.
- Same-cycle conflicts:
  - A register write and timer expiry on the same edge: the register write result wins for the bits it targets.
  - A PULSE write on the expiry edge: the reload wins and nothing is cleared.
- A PULSE_LEN write during RUN does not affect the current count.
- Writes to bits at or above WIDTH are ignored.
- Reset (synchronous, at any point including mid-pulse):
  - data = RESET_VALUE, out_port = RESET_VALUE.
  - active = 0, counter = 0, FSM = IDLE.
  - PULSE_LEN = RESET_PULSE_LEN.

## Timing
- out_port = data register; it changes on the clk edge after the write edge (1 cycle latency).
- A pulse of length L written at edge k holds the bit high from edge k+1 to edge k+1+L, i.e. exactly L cycles.
- readdata has zero wait states and reflects register state as of the current cycle.
- Throughput: one write per cycle, with no back-pressure.

## Structure
- Package nios_system_pio_pkg holds:
  - register offset constants (ADDR_DATA=0, ADDR_PULSE_LEN=1, ADDR_PULSE=2, ADDR_OUTSET=4, ADDR_OUTCLEAR=5);
  - the timer state enum {IDLE, RUN}.
- Sub-module nios_system_pio_pulse_timer holds the shared CNT_W counter and FSM.
  - Inputs: load, len, abort.
  - Output: expire, a 1-cycle strobe.
- The top level contains the register decode, the data and active registers, and the read mux.

## Test plan
- Reset with WIDTH=8, RESET_VALUE=8'hA5 -> out_port=A5, PULSE_LEN reads 1000, PULSE reads 0. Write DATA=0x3C -> out_port=3C one cycle later.
- Set and clear from out_port=0x0F:
  - OUTSET 0xF0 -> FF.
  - then OUTCLEAR 0x81 -> 7E.
  - then writedata 0xFFFFFF00 to DATA -> 00, since upper bits are ignored.
- Pulse: PULSE_LEN=5, then PULSE 0x01 -> bit0 high exactly 5 cycles. PULSE reads 0x01 during the pulse and 0 afterwards. PULSE_LEN=0 -> 1-cycle pulse.
- Retrigger: PULSE_LEN=10, PULSE 0x01, then PULSE 0x02 four cycles later -> both bits drop together 10 cycles after the second write.
- Conflicts:
  - OUTSET 0x01 mid-pulse -> bit0 stays 1 after expiry.
  - OUTCLEAR on the expiry edge -> bit cleared.
  - PULSE on the expiry edge -> reload, no clear.
- Reset asserted mid-pulse -> out_port=RESET_VALUE, active=0, and no stray clear after reset is released.

Source files
------------

// File: rtl/nios_system_pio_pkg.sv
// Shared register map and timer state encoding for the pulse-capable output PIO.
`timescale 1ns/1ps
package nios_system_pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_PULSE     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR  = 3'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/nios_system_pio_pulse_timer.sv
// Shared one-shot down-counter: load starts/restarts a count of max(len,1) cycles,
// expire strobes combinationally during the last counted cycle so the parent can
// clear its pulse bits on the same edge the counter returns to IDLE.
`timescale 1ns/1ps
module nios_system_pio_pulse_timer
  import nios_system_pio_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             expire
);

  timer_state_t     state_q;
  timer_state_t     state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] len_eff;

  // A programmed length of zero still produces a one-cycle pulse.
  assign len_eff = (len == '0) ? CNT_W'(1) : len;

  // State and counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: reload has priority over both expiry and abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = RUN;
      cnt_d   = len_eff;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
        end
        RUN: begin
          if (abort || (cnt_q <= CNT_W'(1))) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Expiry strobe for the final counted cycle, suppressed by a same-cycle reload.
  always_comb begin
    expire = 1'b0;
    if ((state_q == RUN) && (cnt_q == CNT_W'(1)) && !load) begin
      expire = 1'b1;
    end
  end

endmodule

// File: rtl/nios_system_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear registers and a shared one-shot pulse mode.
`timescale 1ns/1ps
module nios_system_pio_out_pulse
  import nios_system_pio_pkg::*;
#(
  parameter int unsigned       WIDTH           = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE     = '0,
  parameter int unsigned       CNT_W           = 16,
  parameter int unsigned       RESET_PULSE_LEN = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [BUS_W-1:0]  writedata,
  output logic [BUS_W-1:0]  readdata,
  output logic [WIDTH-1:0]  out_port
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] active_q;
  logic [WIDTH-1:0] active_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_d;

  logic             wr;
  logic [WIDTH-1:0] mask;
  logic             load;
  logic             abort;
  logic             expire;
  logic             unused_wdata;

  // Bits of writedata above WIDTH/CNT_W are deliberately dropped.
  assign unused_wdata = ^writedata;

  assign wr   = chipselect && !write_n;
  assign mask = writedata[WIDTH-1:0];
  assign load = wr && (address == ADDR_PULSE) && (mask != '0);

  // Pulse run ends early once a register write leaves no bit in pulse mode.
  always_comb begin
    abort = 1'b0;
    if (wr) begin
      case (address)
        ADDR_DATA:     abort = 1'b1;
        ADDR_OUTSET,
        ADDR_OUTCLEAR: abort = ((active_q & ~mask) == '0);
        default:       abort = 1'b0;
      endcase
    end
  end

  nios_system_pio_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .len    (len_q),
    .abort  (abort),
    .expire (expire)
  );

  // Next register values: expiry applied first, then the bus write overrides its bits.
  always_comb begin
    data_d   = data_q;
    active_d = active_q;
    len_d    = len_q;
    if (expire) begin
      data_d   = data_q & ~active_q;
      active_d = '0;
    end
    if (wr) begin
      case (address)
        ADDR_DATA: begin
          data_d   = mask;
          active_d = '0;
        end
        ADDR_PULSE_LEN: begin
          len_d = writedata[CNT_W-1:0];
        end
        ADDR_PULSE: begin
          data_d   = data_d | mask;
          active_d = active_d | mask;
        end
        ADDR_OUTSET: begin
          data_d   = data_d | mask;
          active_d = active_d & ~mask;
        end
        ADDR_OUTCLEAR: begin
          data_d   = data_d & ~mask;
          active_d = active_d & ~mask;
        end
        default: begin
          data_d   = data_d;
        end
      endcase
    end
  end

  // Data, active mask and pulse length registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      active_q <= '0;
      len_q    <= CNT_W'(RESET_PULSE_LEN);
    end else begin
      data_q   <= data_d;
      active_q <= active_d;
      len_q    <= len_d;
    end
  end

  assign out_port = data_q;

  // Zero-wait-state read mux; reserved offsets read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = BUS_W'(data_q);
      ADDR_PULSE_LEN: readdata = BUS_W'(len_q);
      ADDR_PULSE:     readdata = BUS_W'(active_q);
      default:        readdata = '0;
    endcase
  end

endmodule
